iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle integer divider; the inverse arithmetic block to the pipelined multiplier in the same execute datapath.
- Accepts a dividend and a divisor, each with its own per-operand signed/unsigned flag.
- Produces a WIDTH-bit quotient and a WIDTH-bit remainder after a fixed latency.
- Uses a radix-2 restoring shift-subtract loop, one quotient bit per cycle, with a start/ready/valid handshake so the issue logic can stall on it.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (must be ≥ 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op1  input  WIDTH  dividend.
- op1_sign  input  1  1: op1 is two's complement signed; 0: unsigned.
- op2  input  WIDTH  divisor.
- op2_sign  input  1  1: op2 is two's complement signed; 0: unsigned.
- ready  output  1  high when idle and able to accept start.
- valid  output  1  one-cycle pulse: quotient/remainder updated this cycle.
- quotient  output  WIDTH  quotient, truncated toward zero.
- remainder  output  WIDTH  remainder, same sign as the dividend.

Behaviour:
- Reset (rst=1 at an edge), applied to all state on that edge:
  - FSM goes to IDLE; ready=1, valid=0, quotient=0, remainder=0, iteration counter=0.
  - Reset mid-operation abandons the division; no valid is issued for it.
- FSM states:
  - IDLE -> CALC on start&ready. Latch the magnitudes |op1| and |op2| (negated only if the sign flag is set and the MSB is 1), the quotient-negate flag (op1 negative XOR op2 negative), the remainder-negate flag (op1 negative), a div-by-zero flag (op2==0) and an overflow flag (op1_sign&op2_sign&op1=={1,0..0}&op2==all-ones). Counter=WIDTH-1.
  - CALC: each cycle, shift the {rem,quo} register left by 1 bringing in the next dividend bit, trial-subtract the divisor magnitude (WIDTH+1-bit compare), keep the difference and set the quotient LSB if non-negative. Decrement the counter; after the count-0 iteration -> FIX. Exactly WIDTH CALC cycles.
  - FIX: one cycle. Apply the sign corrections, then the special cases, to the outputs. Assert valid for exactly one cycle. -> IDLE.
- Latency: start accepted at edge N -> valid=1 and new results in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles. Latency is constant, including for special cases.
- ready=1 only in IDLE. start while ready=0 is ignored; it is not queued.
- The FSM returns to IDLE on the same edge valid rises, so ready=1 during the valid cycle. A start in that cycle begins the next division back-to-back.
- Outputs quotient/remainder hold their last value until the next FIX. valid is 0 everywhere outside FIX completion.
- Sign handling:
  - Negative results are the two's complement of the magnitude, truncated to WIDTH bits.
  - Mixed signedness: the unsigned operand is always non-negative.
- Special cases, highest priority first:
  - Divide by zero: quotient = all ones, remainder = op1 (original bits).
  - Signed overflow (MIN / -1, both signed): quotient = op1 (MIN), remainder = 0.
  - Unsigned-dividend / signed-negative-divisor results exceeding the signed range: the low WIDTH bits of the exact result; no flag.
- Input operands are only sampled at accept; changes during CALC have no effect.
- rst has priority over start in the same cycle.

Test Plan:
- WIDTH=32, unsigned 100 / 7 (signs 0,0) -> valid exactly 34 cycles after accept; quotient=14, remainder=2; ready=0 during the 33 cycles between.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002, signs 1,1) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero: 0x12345678 / 0 (signs 1,1) -> quotient=0xFFFFFFFF, remainder=0x12345678, same 34-cycle latency.
- Overflow: 0x80000000 / 0xFFFFFFFF (signs 1,1) -> quotient=0x80000000, remainder=0. Same operands unsigned (signs 0,0) -> quotient=0, remainder=0x80000000.
- Back-to-back and ignored start:
  - Start held high throughout: accepted only when ready=1; the second division begins in the cycle its predecessor's valid is high.
  - A start pulse with different operands mid-CALC is ignored, and the results match the first operands.
- Reset mid-operation: assert rst at cycle 10 of CALC -> next cycle ready=1, valid=0, quotient=remainder=0; no valid pulse follows. A fresh 100/7 then completes correctly.

Source files
------------

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed/unsigned
// per operand, fixed WIDTH+2 cycle latency with start/ready/valid handshake.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic             op1_sign,
    input  logic [WIDTH-1:0] op2,
    input  logic             op2_sign,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             valid_q, valid_d;

    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        min_val = {1'b1, {(WIDTH-1){1'b0}}};
        op1_neg = op1_sign & op1[WIDTH-1];
        op2_neg = op2_sign & op2[WIDTH-1];
        op1_mag = op1_neg ? -op1 : op1;
        op2_mag = op2_neg ? -op2 : op2;
        // Partial remainder is always below the divisor, so WIDTH+1 bits suffice
        trial   = {rem_q, quo_q[WIDTH-1]};
        diff    = trial - {1'b0, dvsr_q};

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        op1_d       = op1_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = CW'(WIDTH - 1);
                    rem_d     = '0;
                    quo_d     = op1_mag;
                    dvsr_d    = op2_mag;
                    op1_d     = op1;
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    dbz_d     = (op2 == '0);
                    ovf_d     = op1_sign & op2_sign & (op1 == min_val)
                              & (op2 == '1);
                end
            end
            CALC: begin
                rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = op1_q;
                end else if (ovf_q) begin
                    quotient_d  = op1_q;
                    remainder_d = '0;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            op1_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            op1_q       <= op1_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign valid     = valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: reference results from plain
// 64-bit signed arithmetic, checked by a monitor on every valid pulse.
module tb_iterative_divider;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op1 = '0;
    logic         op1_sign = 1'b0;
    logic [W-1:0] op2 = '0;
    logic         op2_sign = 1'b0;
    logic         ready, valid;
    logic [W-1:0] quotient, remainder;

    iterative_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op1      (op1),
        .op1_sign (op1_sign),
        .op2      (op2),
        .op2_sign (op2_sign),
        .ready    (ready),
        .valid    (valid),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           free_cyc = 0;
    bit           armed = 1'b0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    int           errors = 0;
    int           checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h",
                     name, cyc, act, req);
        end
    endtask

    function automatic exp_t ref_div(input logic [W-1:0] a, input bit sa,
                                     input logic [W-1:0] b, input bit sb_);
        exp_t   e;
        longint x, y, q, r;
        x = sa  ? longint'($signed(a)) : longint'({32'h0, a});
        y = sb_ ? longint'($signed(b)) : longint'({32'h0, b});
        e.due = 0;
        if (y == 0) begin
            e.q = '1;
            e.r = a;
        end else if (sa && sb_ && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = '0;
        end else begin
            q   = x / y;
            r   = x % y;
            e.q = q[W-1:0];
            e.r = r[W-1:0];
        end
        return e;
    endfunction

    // Monitor and scoreboard: everything sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("ready", {31'b0, ready}, {31'b0, (cyc >= free_cyc)});
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("latency_cycle", cyc, e.due);
                    last_q = e.q;
                    last_r = e.r;
                end
            end else begin
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                if (sb.size() != 0 && cyc > sb[0].due) begin
                    chk("missing_valid", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
        if (rst) begin
            sb.delete();
            free_cyc = cyc + 1;
            armed    = 1'b1;
            last_q   = '0;
            last_r   = '0;
        end else if (armed && start && cyc >= free_cyc) begin
            e     = ref_div(op1, op1_sign, op2, op2_sign);
            e.due = cyc + LAT;
            sb.push_back(e);
            free_cyc = cyc + LAT;
        end
    end

    task automatic issue(input logic [W-1:0] a, input bit sa,
                         input logic [W-1:0] b, input bit sb_);
        for (int i = 0; i < 200 && cyc < free_cyc; i++) begin
            @(posedge clk);
            #1;
        end
        op1      = a;
        op1_sign = sa;
        op2      = b;
        op2_sign = sb_;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && (sb.size() != 0 || cyc < free_cyc); i++)
            @(posedge clk);
        #1;
        if (sb.size() != 0 || cyc < free_cyc) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout cycle %0d: pending %0d", cyc, sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h8000_0000;
            3:       v = W'($urandom_range(0, 20));
            4:       v = -W'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        issue(32'd100, 0, 32'd7, 0);
        wait_idle();
        issue(32'hFFFF_FFF9, 1, 32'd2, 1);
        issue(32'd7, 1, 32'hFFFF_FFFE, 1);
        issue(32'h1234_5678, 1, 32'd0, 1);
        issue(32'h8000_0000, 1, 32'hFFFF_FFFF, 1);
        issue(32'h8000_0000, 0, 32'hFFFF_FFFF, 0);
        issue(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1);
        issue(32'h8000_0000, 1, 32'd1, 0);
        wait_idle();

        // Start pulse mid-division with other operands must be ignored
        issue(32'd1000, 0, 32'd9, 0);
        repeat (5) @(posedge clk);
        #1;
        op1   = 32'd999;
        op2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Start held high: accepts only when ready, back-to-back
        start = 1'b1;
        for (int i = 0; i < 110; i++) begin
            op1      = pick();
            op2      = pick();
            op1_sign = 1'($urandom_range(0, 1));
            op2_sign = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        // Reset during the tenth CALC cycle
        issue(32'd100, 0, 32'd7, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        issue(32'd100, 0, 32'd7, 0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            issue(pick(), 1'($urandom_range(0, 1)),
                  pick(), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
